// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator-machine controller/sequencer:
// state encoding, opcodes and control-word bit layout.
package acc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [3:0] OPC_LDA = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_MBA = 4'h3;
    localparam logic [3:0] OPC_OUT = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam int CW_W   = 13;
    localparam int CW_CP  = 0;
    localparam int CW_EP  = 1;
    localparam int CW_LMN = 2;
    localparam int CW_CEN = 3;
    localparam int CW_LIN = 4;
    localparam int CW_EIN = 5;
    localparam int CW_IAN = 6;
    localparam int CW_EAN = 7;
    localparam int CW_IBN = 8;
    localparam int CW_EBN = 9;
    localparam int CW_SU  = 10;
    localparam int CW_EU  = 11;
    localparam int CW_LON = 12;

    // Every control at its deasserted level: active-low bits (LMn..EBn, LOn) high.
    localparam logic [CW_W-1:0] CW_IDLE = 13'b1_0011_1111_1100;

endpackage

// File: rtl/acc_ctrl_dec.sv
// Combinational control-word decoder: (state, opcode) -> raw control levels.
module acc_ctrl_dec
    import acc_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  state_t          i_state,
    input  logic [OP_W-1:0] i_op,
    output logic [CW_W-1:0] o_cw
);

    always_comb begin
        o_cw = CW_IDLE;
        case (i_state)
            S_T1: begin
                o_cw[CW_EP]  = 1'b1;
                o_cw[CW_LMN] = 1'b0;
            end
            S_T2: o_cw[CW_CP] = 1'b1;
            S_T3: begin
                o_cw[CW_CEN] = 1'b0;
                o_cw[CW_LIN] = 1'b0;
            end
            S_T4: begin
                case (i_op)
                    OP_W'(OPC_LDA), OP_W'(OPC_ADD), OP_W'(OPC_SUB): begin
                        o_cw[CW_EIN] = 1'b0;
                        o_cw[CW_LMN] = 1'b0;
                    end
                    OP_W'(OPC_MBA): begin
                        o_cw[CW_EBN] = 1'b0;
                        o_cw[CW_IAN] = 1'b0;
                    end
                    OP_W'(OPC_OUT): begin
                        o_cw[CW_EAN] = 1'b0;
                        o_cw[CW_LON] = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (i_op)
                    OP_W'(OPC_LDA): begin
                        o_cw[CW_CEN] = 1'b0;
                        o_cw[CW_IAN] = 1'b0;
                    end
                    OP_W'(OPC_ADD), OP_W'(OPC_SUB): begin
                        o_cw[CW_CEN] = 1'b0;
                        o_cw[CW_IBN] = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                // ADD and SUB share the write-back; only the ALU mode differs.
                if (i_op == OP_W'(OPC_ADD) || i_op == OP_W'(OPC_SUB)) begin
                    o_cw[CW_EU]  = 1'b1;
                    o_cw[CW_IAN] = 1'b0;
                    o_cw[CW_SU]  = (i_op == OP_W'(OPC_SUB));
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_ctrl_seq.sv
// Ring-counter style sequencer: holds the T-state register and exposes the
// decoded control word on individual control pins.
module acc_ctrl_seq
    import acc_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            RUN,
    input  logic [OP_W-1:0] IR_op,
    output logic            Cp,
    output logic            Ep,
    output logic            LMn,
    output logic            CEn,
    output logic            LIn,
    output logic            EIn,
    output logic            IAn,
    output logic            EAn,
    output logic            IBn,
    output logic            EBn,
    output logic            Su,
    output logic            Eu,
    output logic            LOn,
    output logic            HLT,
    output logic [2:0]      TSTATE
);

    state_t          r_state;
    logic [CW_W-1:0] w_cw;

    // RUN only matters at instruction boundaries (IDLE and T6).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: r_state <= RUN ? S_T1 : S_IDLE;
                S_T1:   r_state <= S_T2;
                S_T2:   r_state <= S_T3;
                S_T3:   r_state <= S_T4;
                S_T4:   r_state <= (IR_op == OP_W'(OPC_HLT)) ? S_HALT : S_T5;
                S_T5:   r_state <= S_T6;
                S_T6:   r_state <= RUN ? S_T1 : S_IDLE;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    acc_ctrl_dec #(.OP_W(OP_W)) u_dec (
        .i_state (r_state),
        .i_op    (IR_op),
        .o_cw    (w_cw)
    );

    assign Cp  = w_cw[CW_CP];
    assign Ep  = w_cw[CW_EP];
    assign LMn = w_cw[CW_LMN];
    assign CEn = w_cw[CW_CEN];
    assign LIn = w_cw[CW_LIN];
    assign EIn = w_cw[CW_EIN];
    assign IAn = w_cw[CW_IAN];
    assign EAn = w_cw[CW_EAN];
    assign IBn = w_cw[CW_IBN];
    assign EBn = w_cw[CW_EBN];
    assign Su  = w_cw[CW_SU];
    assign Eu  = w_cw[CW_EU];
    assign LOn = w_cw[CW_LON];

    assign HLT    = (r_state == S_HALT);
    assign TSTATE = (r_state == S_HALT) ? 3'd0 : r_state;

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Directed table-driven bench for acc_ctrl_seq plus HALT and reset-in-T5 sequences.
module tb_acc_ctrl_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RUN = 1'b0;
    logic [3:0] IR_op = 4'h0;
    logic       Cp, Ep, LMn, CEn, LIn, EIn, IAn, EAn, IBn, EBn, Su, Eu, LOn, HLT;
    logic [2:0] TSTATE;

    int checks = 0;
    int errors = 0;

    // Asserted-sense view of the controls, MSB first: Cp Ep LM CE LI EI IA EA IB EB Su Eu LO
    localparam logic [12:0] A_CP = 13'h1000, A_EP = 13'h0800, A_LM = 13'h0400,
                            A_CE = 13'h0200, A_LI = 13'h0100, A_EI = 13'h0080,
                            A_IA = 13'h0040, A_EA = 13'h0020, A_IB = 13'h0010,
                            A_EB = 13'h0008, A_SU = 13'h0004, A_EU = 13'h0002,
                            A_LO = 13'h0001, A_NONE = 13'h0000;

    logic [12:0] w_act;
    assign w_act = {Cp, Ep, ~LMn, ~CEn, ~LIn, ~EIn, ~IAn, ~EAn, ~IBn, ~EBn, Su, Eu, ~LOn};

    acc_ctrl_seq #(.OP_W(4)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .IR_op(IR_op),
        .Cp(Cp), .Ep(Ep), .LMn(LMn), .CEn(CEn), .LIn(LIn), .EIn(EIn),
        .IAn(IAn), .EAn(EAn), .IBn(IBn), .EBn(EBn), .Su(Su), .Eu(Eu),
        .LOn(LOn), .HLT(HLT), .TSTATE(TSTATE)
    );

    always #5 CLK = ~CLK;

    // Bus-driver exclusivity on every cycle.
    always @(negedge CLK) begin
        checks++;
        if ($countones({Ep, ~CEn, ~EIn, ~EAn, ~EBn, Eu}) > 1) begin
            errors++;
            $display("FAIL bus_excl t=%0t drivers Ep=%b CEn=%b EIn=%b EAn=%b EBn=%b Eu=%b",
                     $time, Ep, CEn, EIn, EAn, EBn, Eu);
        end
    end

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  op;
        logic [2:0]  ts;
        logic [12:0] act;
        logic        hlt;
    } vec_t;

    vec_t tbl[64];
    int   n = 0;

    task automatic add(input logic rst, input logic run, input logic [3:0] op,
                       input logic [2:0] ts, input logic [12:0] act, input logic hlt);
        tbl[n].rst = rst; tbl[n].run = run; tbl[n].op = op;
        tbl[n].ts = ts; tbl[n].act = act; tbl[n].hlt = hlt;
        n++;
    endtask

    task automatic step(input logic rst, input logic run, input logic [3:0] op);
        RST = rst; RUN = run; IR_op = op;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] ts,
                       input logic [12:0] act, input logic hlt);
        checks++;
        if (TSTATE !== ts) begin
            errors++;
            $display("FAIL %s tstate got %0d exp %0d", name, TSTATE, ts);
        end
        checks++;
        if (w_act !== act) begin
            errors++;
            $display("FAIL %s controls got %013b exp %013b", name, w_act, act);
        end
        checks++;
        if (HLT !== hlt) begin
            errors++;
            $display("FAIL %s hlt got %b exp %b", name, HLT, hlt);
        end
    endtask

    initial begin
        // reset two cycles, then idle
        add(1, 0, 4'h0, 0, A_NONE, 0);
        add(1, 0, 4'h0, 0, A_NONE, 0);
        add(0, 0, 4'h0, 0, A_NONE, 0);
        // ADD
        add(0, 1, 4'h1, 1, A_EP | A_LM, 0);
        add(0, 1, 4'h1, 2, A_CP, 0);
        add(0, 1, 4'h1, 3, A_CE | A_LI, 0);
        add(0, 1, 4'h1, 4, A_EI | A_LM, 0);
        add(0, 1, 4'h1, 5, A_CE | A_IB, 0);
        add(0, 1, 4'h1, 6, A_EU | A_IA, 0);
        // SUB
        add(0, 1, 4'h2, 1, A_EP | A_LM, 0);
        add(0, 1, 4'h2, 2, A_CP, 0);
        add(0, 1, 4'h2, 3, A_CE | A_LI, 0);
        add(0, 1, 4'h2, 4, A_EI | A_LM, 0);
        add(0, 1, 4'h2, 5, A_CE | A_IB, 0);
        add(0, 1, 4'h2, 6, A_EU | A_SU | A_IA, 0);
        // MBA
        add(0, 1, 4'h3, 1, A_EP | A_LM, 0);
        add(0, 1, 4'h3, 2, A_CP, 0);
        add(0, 1, 4'h3, 3, A_CE | A_LI, 0);
        add(0, 1, 4'h3, 4, A_EB | A_IA, 0);
        add(0, 1, 4'h3, 5, A_NONE, 0);
        add(0, 1, 4'h3, 6, A_NONE, 0);
        // OUT
        add(0, 1, 4'hE, 1, A_EP | A_LM, 0);
        add(0, 1, 4'hE, 2, A_CP, 0);
        add(0, 1, 4'hE, 3, A_CE | A_LI, 0);
        add(0, 1, 4'hE, 4, A_EA | A_LO, 0);
        add(0, 1, 4'hE, 5, A_NONE, 0);
        add(0, 1, 4'hE, 6, A_NONE, 0);
        // LDA
        add(0, 1, 4'h0, 1, A_EP | A_LM, 0);
        add(0, 1, 4'h0, 2, A_CP, 0);
        add(0, 1, 4'h0, 3, A_CE | A_LI, 0);
        add(0, 1, 4'h0, 4, A_EI | A_LM, 0);
        add(0, 1, 4'h0, 5, A_CE | A_IA, 0);
        add(0, 1, 4'h0, 6, A_NONE, 0);
        // NOP opcode, RUN dropped while in T3: instruction still completes
        add(0, 1, 4'h5, 1, A_EP | A_LM, 0);
        add(0, 1, 4'h5, 2, A_CP, 0);
        add(0, 1, 4'h5, 3, A_CE | A_LI, 0);
        add(0, 0, 4'h5, 4, A_NONE, 0);
        add(0, 0, 4'h5, 5, A_NONE, 0);
        add(0, 0, 4'h5, 6, A_NONE, 0);
        add(0, 0, 4'h5, 0, A_NONE, 0);
        add(0, 1, 4'h5, 1, A_EP | A_LM, 0);

        for (int i = 0; i < n; i++) begin
            step(tbl[i].rst, tbl[i].run, tbl[i].op);
            chk($sformatf("vec%0d", i), tbl[i].ts, tbl[i].act, tbl[i].hlt);
        end

        // HLT: fetch, inactive T4, then stuck in HALT despite RUN until RST
        step(1, 0, 4'hF);
        chk("hlt_rst", 0, A_NONE, 0);
        step(0, 1, 4'hF); chk("hlt_t1", 1, A_EP | A_LM, 0);
        step(0, 1, 4'hF); chk("hlt_t2", 2, A_CP, 0);
        step(0, 1, 4'hF); chk("hlt_t3", 3, A_CE | A_LI, 0);
        step(0, 1, 4'hF); chk("hlt_t4", 4, A_NONE, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 4'hF);
            chk($sformatf("halt%0d", k), 0, A_NONE, 1);
        end
        step(1, 1, 4'hF); chk("halt_exit", 0, A_NONE, 0);
        step(0, 0, 4'hF); chk("halt_idle", 0, A_NONE, 0);

        // RST in T5 of ADD aborts the instruction
        step(0, 1, 4'h1); chk("abt_t1", 1, A_EP | A_LM, 0);
        step(0, 1, 4'h1); chk("abt_t2", 2, A_CP, 0);
        step(0, 1, 4'h1); chk("abt_t3", 3, A_CE | A_LI, 0);
        step(0, 1, 4'h1); chk("abt_t4", 4, A_EI | A_LM, 0);
        step(0, 1, 4'h1); chk("abt_t5", 5, A_CE | A_IB, 0);
        step(1, 1, 4'h1); chk("abt_rst", 0, A_NONE, 0);
        step(0, 1, 4'h1); chk("abt_restart", 1, A_EP | A_LM, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_ctrl_seq.md
ACC_CTRL_SEQ -- requirements
Module: acc_ctrl_seq

Interface
REQ-001 Parameter OP_W, default 4, opcode width.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous reset, active-high.
REQ-004 RUN  input  1  start/continue enable, sampled at instruction boundaries.
REQ-005 IR_op  input  OP_W  opcode field of instruction register, valid from T4 onward.
REQ-006 Cp  output  1  PC increment, active-high.
REQ-007 Ep  output  1  PC to bus, active-high.
REQ-008 LMn  output  1  MAR load, active-low.
REQ-009 CEn  output  1  RAM to bus, active-low.
REQ-010 LIn  output  1  IR load, active-low.
REQ-011 EIn  output  1  IR address field to bus, active-low.
REQ-012 IAn  output  1  accumulator A load, active-low.
REQ-013 EAn  output  1  accumulator A to bus, active-low.
REQ-014 IBn  output  1  register B load, active-low.
REQ-015 EBn  output  1  register B to bus, active-low.
REQ-016 Su  output  1  ALU subtract select, active-high.
REQ-017 Eu  output  1  ALU result to bus, active-high.
REQ-018 LOn  output  1  output register load, active-low.
REQ-019 HLT  output  1  halted flag, active-high.
REQ-020 TSTATE  output  3  current T-state index (0 = IDLE/HALT, 1..6 = T1..T6), for debug.

Function
REQ-021 States: IDLE, T1..T6, HALT; state held in registers, control outputs decoded combinationally from state and IR_op.
REQ-022 IDLE -> T1 when RUN=1; else stay IDLE; all controls inactive.
REQ-023 T1: Ep=1, LMn=0. T2: Cp=1. T3: CEn=0, LIn=0. Fetch identical for every opcode.
REQ-024 LDA (0x0): T4 EIn=0, LMn=0; T5 CEn=0, IAn=0; T6 none.
REQ-025 ADD (0x1): T4 EIn=0, LMn=0; T5 CEn=0, IBn=0; T6 Eu=1, Su=0, IAn=0.
REQ-026 SUB (0x2): as ADD except T6 Su=1.
REQ-027 MBA (0x3): T4 EBn=0, IAn=0; T5, T6 none.
REQ-028 OUT (0xE): T4 EAn=0, LOn=0; T5, T6 none.
REQ-029 HLT (0xF): T4 controls inactive; next edge -> HALT; HLT=1 in HALT; HALT exited only by RST.
REQ-030 Any other opcode: T4..T6 no controls (NOP).
REQ-031 T6 -> T1 if RUN=1, else IDLE; RUN ignored in T1..T5 (no mid-instruction pause).
REQ-032 At most one bus driver (Ep, CEn, EIn, EAn, EBn, Eu) active in any state; violation is a design error.
REQ-033 Every inactive control at its deasserted level: active-high signals 0, active-low signals 1.
REQ-034 RST=1 overrides RUN and all transitions, including mid-instruction and HALT.

Reset
REQ-035 On RST: state IDLE, TSTATE=0, HLT=0, Cp=Ep=Su=Eu=0, all active-low controls 1.

Structure
REQ-036 Shared package acc_ctrl_pkg: state enumeration, opcode constants (LDA, ADD, SUB, MBA, OUT, HLT), control-word bit positions.
REQ-037 One sub-module acc_ctrl_dec: pure combinational map (state, IR_op) -> control word; acc_ctrl_seq holds the state register.

Verification
REQ-038 RST=1 two cycles, RUN=0 -> IDLE, all controls inactive, TSTATE=0, HLT=0.
REQ-039 RUN=1, IR_op=0x1 -> T1 Ep=1/LMn=0; T2 Cp=1; T3 CEn=0/LIn=0; T4 EIn=0/LMn=0; T5 CEn=0/IBn=0; T6 Eu=1/Su=0/IAn=0; then T1.
REQ-040 IR_op=0x2 -> T6 Eu=1, Su=1, IAn=0; IR_op=0x3 -> T4 EBn=0, IAn=0; IR_op=0xE -> T4 EAn=0, LOn=0.
REQ-041 IR_op=0xF -> fetch T1..T3, T4 inactive, then HALT with HLT=1 for 10 cycles despite RUN=1; RST -> IDLE.
REQ-042 RUN dropped in T3 -> instruction completes T4..T6, then IDLE; RUN=1 -> T1 next edge.
REQ-043 RST asserted in T5 of ADD -> next edge IDLE, IBn=1, IAn=1; bus-driver exclusivity checked by assertion on all cycles.
